// File: rtl/mac_ants_pkg.sv
// Shared widths, types and the round/shift/narrow helper for the antenna MAC accumulator.
package mac_ants_pkg;

  localparam int CPLX_W = 64;

  typedef logic signed [CPLX_W-1:0] wide_t;

  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  // Full complex product: two IW/2 x IW/2 products plus one bit for the add/sub.
  function automatic int calc_pw(input int iw);
    return iw + 1;
  endfunction

  function automatic int calc_tw(input int iw, input int ant);
    return calc_pw(iw) + $clog2(ant);
  endfunction

  function automatic int calc_acc_w(input int iw, input int ant, input int acc_max);
    return calc_tw(iw, ant) + $clog2(acc_max);
  endfunction

  // Round half up, arithmetic shift, then optionally clamp to a signed ow-bit range.
  function automatic wide_t round_shift_sat(input wide_t x, input int shift, input int ow,
                                            input logic sat);
    wide_t r;
    wide_t hi;
    wide_t lo;
    r = x;
    if (shift > 0) begin
      r = (x + (wide_t'(1) <<< (shift - 1))) >>> shift;
    end
    hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (ow - 1));
    if (sat) begin
      if (r > hi) begin
        r = hi;
      end else if (r < lo) begin
        r = lo;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/add_tree_pipe.sv
// Registered pairwise adder tree: log2(N) stages, each widening by one sign-extended bit.
module add_tree_pipe #(
  parameter int N = 32,
  parameter int W = 33
) (
  input  logic                          i_clk,
  input  logic [N*W-1:0]                i_data,
  output logic signed [W+$clog2(N)-1:0] o_sum
);

  localparam int TD = $clog2(N);

  for (genvar gi = 0; gi <= TD; gi++) begin : g_lvl
    localparam int NN = N >> gi;
    localparam int LW = W + gi;
    logic signed [LW-1:0] node [NN];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < NN; gj++) begin : g_n
        assign node[gj] = i_data[gj*W +: W];
      end
    end else begin : g_add
      logic signed [LW-1:0] pair_sum [NN];
      for (genvar gj = 0; gj < NN; gj++) begin : g_n
        assign pair_sum[gj] = LW'(g_lvl[gi-1].node[2*gj]) + LW'(g_lvl[gi-1].node[2*gj+1]);
      end
      always_ff @(posedge i_clk) begin
        node <= pair_sum;
      end
    end
  end

  assign o_sum = g_lvl[TD].node[0];

endmodule

// File: rtl/cmpy_mult_s16xs16.sv
// Signed complex multiplier, {re, im} halves in and out, fixed three-cycle latency.
module cmpy_mult_s16xs16 #(
  parameter int HW = 16
) (
  input  logic              i_clk,
  input  logic [2*HW-1:0]   i_a,
  input  logic [2*HW-1:0]   i_b,
  output logic [4*HW+1:0]   o_p
);

  localparam int PR = 2 * HW;

  logic signed [HW-1:0] a_re_reg, a_im_reg, b_re_reg, b_im_reg;
  logic signed [PR-1:0] rr_reg, ii_reg, ri_reg, ir_reg;
  logic signed [PR:0]   p_re_reg, p_im_reg;

  always_ff @(posedge i_clk) begin
    a_re_reg <= i_a[2*HW-1:HW];
    a_im_reg <= i_a[HW-1:0];
    b_re_reg <= i_b[2*HW-1:HW];
    b_im_reg <= i_b[HW-1:0];
    rr_reg   <= PR'(a_re_reg) * PR'(b_re_reg);
    ii_reg   <= PR'(a_im_reg) * PR'(b_im_reg);
    ri_reg   <= PR'(a_re_reg) * PR'(b_im_reg);
    ir_reg   <= PR'(a_im_reg) * PR'(b_re_reg);
    p_re_reg <= (PR+1)'(rr_reg) - (PR+1)'(ii_reg);
    p_im_reg <= (PR+1)'(ri_reg) + (PR+1)'(ir_reg);
  end

  assign o_p = {p_re_reg, p_im_reg};

endmodule

// File: rtl/mac_ants_acc.sv
// Framed complex MAC over ANT antennas with group accumulation and rounded narrowing.
// Define MAC_ANTS_ACC_SAT_EN to clamp the narrowed result instead of wrapping.
module mac_ants_acc
  import mac_ants_pkg::*;
#(
  parameter int ANT      = 32,
  parameter int IW       = 32,
  parameter int OW       = 32,
  parameter int MULT_LAT = 3,
  parameter int ACC_MAX  = 64,
  parameter int SHIFT    = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ANT*IW-1:0] i_ants_data,
  input  logic [ANT*IW-1:0] i_code_word,
  input  logic              i_rvalid,
  input  logic              i_sop,
  input  logic              i_eop,
  output logic [2*OW-1:0]   o_sum_data,
  output logic              o_valid,
  output logic              o_err
);

  localparam int TD    = $clog2(ANT);
  localparam int PW    = calc_pw(IW);
  localparam int TW    = calc_tw(IW, ANT);
  localparam int ACC_W = calc_acc_w(IW, ANT, ACC_MAX);
  localparam int CW    = $clog2(ACC_MAX) + 1;
  localparam int SD    = 1 + MULT_LAT + TD;

`ifdef MAC_ANTS_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [ANT*IW-1:0] ants_reg, code_reg;
  logic [SD-1:0]     vld_pipe_reg, sop_pipe_reg, eop_pipe_reg;

  always_ff @(posedge i_clk) begin
    ants_reg <= i_ants_data;
    code_reg <= i_code_word;
  end

  // Framing bits ride alongside the data; sop/eop are only meaningful with valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_pipe_reg <= '0;
      sop_pipe_reg <= '0;
      eop_pipe_reg <= '0;
    end else begin
      vld_pipe_reg <= {vld_pipe_reg[SD-2:0], i_rvalid};
      sop_pipe_reg <= {sop_pipe_reg[SD-2:0], i_rvalid & i_sop};
      eop_pipe_reg <= {eop_pipe_reg[SD-2:0], i_rvalid & i_eop};
    end
  end

  // MULT_LAT must equal the multiplier's fixed latency so the framing bits stay aligned.
  logic [2*PW-1:0]   prod [ANT];
  logic [ANT*PW-1:0] prod_re, prod_im;

  for (genvar gi = 0; gi < ANT; gi++) begin : g_mult
    cmpy_mult_s16xs16 #(.HW(IW / 2)) u_mult (
      .i_clk (i_clk),
      .i_a   (ants_reg[gi*IW +: IW]),
      .i_b   (code_reg[gi*IW +: IW]),
      .o_p   (prod[gi])
    );
    assign prod_re[gi*PW +: PW] = prod[gi][2*PW-1:PW];
    assign prod_im[gi*PW +: PW] = prod[gi][PW-1:0];
  end

  logic signed [TW-1:0] sum_re, sum_im;

  add_tree_pipe #(.N(ANT), .W(PW)) u_tree_re (
    .i_clk  (i_clk),
    .i_data (prod_re),
    .o_sum  (sum_re)
  );

  add_tree_pipe #(.N(ANT), .W(PW)) u_tree_im (
    .i_clk  (i_clk),
    .i_data (prod_im),
    .o_sum  (sum_im)
  );

  logic t_vld, t_sop, t_eop;
  assign t_vld = vld_pipe_reg[SD-1];
  assign t_sop = sop_pipe_reg[SD-1];
  assign t_eop = eop_pipe_reg[SD-1];

  acc_state_e            state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
  logic signed [ACC_W-1:0] acc_re_reg, acc_im_reg, acc_re_next, acc_im_next;
  logic signed [ACC_W-1:0] base_re, base_im;
  logic                  done_reg, done_next, err_reg, err_next;
  logic                  start, frame_err, force_eop;

  // A beat in IDLE without sop, or a sop while accumulating, is an error but still starts a group.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_re_next = acc_re_reg;
    acc_im_next = acc_im_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    start       = 1'b0;
    frame_err   = 1'b0;
    force_eop   = 1'b0;
    cnt_inc     = cnt_reg;
    base_re     = acc_re_reg;
    base_im     = acc_im_reg;
    if (t_vld) begin
      start     = (state_reg == IDLE) || t_sop;
      frame_err = (state_reg == IDLE) ? !t_sop : t_sop;
      cnt_inc   = start ? CW'(1) : cnt_reg + CW'(1);
      force_eop = !t_eop && (cnt_inc == CW'(ACC_MAX));
      if (start) begin
        base_re = '0;
        base_im = '0;
      end
      acc_re_next = base_re + ACC_W'(sum_re);
      acc_im_next = base_im + ACC_W'(sum_im);
      done_next   = t_eop || force_eop;
      err_next    = frame_err || force_eop;
      cnt_next    = done_next ? '0 : cnt_inc;
      state_next  = done_next ? IDLE : ACC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge i_clk) begin
    acc_re_reg <= acc_re_next;
    acc_im_reg <= acc_im_next;
  end

  cplx_t rs;

  always_comb begin
    rs.re = round_shift_sat(wide_t'(acc_re_reg), SHIFT, OW, SAT_EN);
    rs.im = round_shift_sat(wide_t'(acc_im_reg), SHIFT, OW, SAT_EN);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_sum_data <= '0;
    end else begin
      o_valid <= done_reg;
      o_err   <= err_reg;
      if (done_reg) begin
        o_sum_data <= {OW'(rs.re), OW'(rs.im)};
      end
    end
  end

endmodule

// File: tb/tb_mac_ants_acc.sv
// Scoreboard bench for mac_ants_acc: default instance plus a SHIFT=2, OW=16 instance on shared inputs.
module tb_mac_ants_acc;

  localparam int ANT     = 32;
  localparam int IW      = 32;
  localparam int L       = 11;
  localparam int ACC_MAX = 64;

`ifdef MAC_ANTS_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ANT*IW-1:0] ants, code;
  logic              rvalid, sop, eop;
  logic [63:0]       sum1;
  logic [31:0]       sum2;
  logic              v1, e1, v2, e2;

  mac_ants_acc u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ants_data (ants),
    .i_code_word (code),
    .i_rvalid    (rvalid),
    .i_sop       (sop),
    .i_eop       (eop),
    .o_sum_data  (sum1),
    .o_valid     (v1),
    .o_err       (e1)
  );

  mac_ants_acc #(.SHIFT(2), .OW(16)) u_dut2 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ants_data (ants),
    .i_code_word (code),
    .i_rvalid    (rvalid),
    .i_sop       (sop),
    .i_eop       (eop),
    .o_sum_data  (sum2),
    .o_valid     (v2),
    .o_err       (e2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [63:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t   exp_q[$];
  int     err_q[$];
  int     total = 0;
  int     bad = 0;
  int     valid_seen = 0;
  int     err_seen = 0;
  int     m_state = 0;
  int     m_cnt = 0;
  longint m_re = 0;
  longint m_im = 0;
  logic [63:0] last_d1 = '0;

  function automatic logic [ANT*IW-1:0] fill(input logic [IW-1:0] w);
    return {ANT{w}};
  endfunction

  function automatic logic [31:0] narrow(input longint v, input int sh, input int ow);
    longint r, hi, lo;
    logic [31:0] mask;
    r = v;
    if (sh > 0) r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (SAT) begin
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
    end
    mask = (ow >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1);
    return 32'(r) & mask;
  endfunction

  task automatic drive_beat(input logic [ANT*IW-1:0] a, input logic [ANT*IW-1:0] c,
                            input bit s, input bit e);
    longint sre, sim, ar, ai, br, bi;
    bit start, err, done;
    exp_t x;
    logic [31:0] n1r, n1i, n2r, n2i;
    @(posedge clk); #1;
    ants = a; code = c; rvalid = 1'b1; sop = s; eop = e;
    sre = 0; sim = 0;
    for (int k = 0; k < ANT; k++) begin
      ar = $signed(a[k*IW + IW/2 +: IW/2]);
      ai = $signed(a[k*IW +: IW/2]);
      br = $signed(c[k*IW + IW/2 +: IW/2]);
      bi = $signed(c[k*IW +: IW/2]);
      sre += ar * br - ai * bi;
      sim += ar * bi + ai * br;
    end
    start = (m_state == 0) || s;
    err   = (m_state == 0) ? !s : s;
    if (start) begin
      m_re = sre; m_im = sim; m_cnt = 1;
    end else begin
      m_re += sre; m_im += sim; m_cnt++;
    end
    done = e || (m_cnt == ACC_MAX);
    if (!e && m_cnt == ACC_MAX) err = 1'b1;
    if (done) begin
      n1r = narrow(m_re, 0, 32);
      n1i = narrow(m_im, 0, 32);
      n2r = narrow(m_re, 2, 16);
      n2i = narrow(m_im, 2, 16);
      x.due = cyc + L;
      x.d1 = {n1r, n1i};
      x.d2 = {n2r[15:0], n2i[15:0]};
      exp_q.push_back(x);
      last_d1 = x.d1;
      m_state = 0;
    end else begin
      m_state = 1;
    end
    if (err) err_q.push_back(cyc + L);
  endtask

  // Invalid cycles carry junk with sop/eop high; the DUT must ignore them.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rvalid = 1'b0; sop = 1'b1; eop = 1'b1;
      ants = {ANT{$urandom}}; code = {ANT{$urandom}};
    end
  endtask

  task automatic wait_drain(output bit ok);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && err_q.size() == 0) break;
      @(negedge clk);
    end
    ok = (exp_q.size() == 0 && err_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic run_monitor();
    exp_t e;
    bit ev, ee;
    forever begin
      @(negedge clk);
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (v1 || v2 || ev) begin
        total++;
        if (v1 !== ev || v2 !== ev) begin
          bad++;
          $display("FAIL valid_timing cyc=%0d got=%b/%b required=%b", cyc, v1, v2, ev);
        end
        if (ev) begin
          e = exp_q.pop_front();
          total++;
          if (sum1 !== e.d1 || sum2 !== e.d2) begin
            bad++;
            $display("FAIL sum_data cyc=%0d got=%h/%h required=%h/%h", cyc, sum1, sum2, e.d1, e.d2);
          end
          $display("result cyc=%0d sum1=%h sum2=%h", cyc, sum1, sum2);
        end
        if (v1) valid_seen++;
      end
      ee = (err_q.size() > 0) && (err_q[0] == cyc);
      if (ee) void'(err_q.pop_front());
      if (e1 || e2 || ee) begin
        total++;
        if (e1 !== ee || e2 !== ee) begin
          bad++;
          $display("FAIL err_pulse cyc=%0d got=%b/%b required=%b", cyc, e1, e2, ee);
        end
        if (e1) err_seen++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rvalid = 1'b0; sop = 1'b0; eop = 1'b0; ants = '0; code = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (v1 !== 1'b0 || v2 !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b/%b required=0/0", v1, v2);
    end
    total++;
    if (e1 !== 1'b0 || e2 !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b/%b required=0/0", e1, e2);
    end
    total++;
    if (sum1 !== 64'd0 || sum2 !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h required=0/0", sum1, sum2);
    end
    $display("reset checked cyc=%0d", cyc);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b1, 1'b1);
    idle(3);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_drain pending=%0d required=0", exp_q.size()); end
    repeat (4) @(negedge clk);
    total++;
    if (sum1 !== 64'h0000_0020_0000_0000) begin
      bad++; $display("FAIL single_hold got=%h required=%h", sum1, 64'h0000_0020_0000_0000);
    end
  endtask

  task automatic test_sign();
    bit ok;
    drive_beat(fill(32'h0000_0001), fill(32'h0000_0001), 1'b1, 1'b1);
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL sign_drain pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_accumulate();
    bit ok;
    for (int i = 0; i < 4; i++)
      drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), i == 0, i == 3);
    drive_beat(fill(32'h0002_0001), fill(32'h0001_0000), 1'b1, 1'b0);
    drive_beat(fill(32'h0002_0001), fill(32'h0001_0000), 1'b0, 1'b1);
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL accumulate_drain pending=%0d required=0", exp_q.size()); end
    repeat (3) @(negedge clk);
    total++;
    if (sum1 !== last_d1) begin
      bad++; $display("FAIL accumulate_hold got=%h required=%h", sum1, last_d1);
    end
  endtask

  task automatic test_rounding();
    bit ok;
    logic [ANT*IW-1:0] a, c;
    a = '0; c = '0;
    c[31:16] = 16'sd1;
    a[31:16] = 16'sd34;
    drive_beat(a, c, 1'b1, 1'b1);
    a[31:16] = -16'sd34;
    drive_beat(a, c, 1'b1, 1'b1);
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rounding_drain pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < ACC_MAX; i++)
      drive_beat(fill(32'h7FFF_0000), fill(32'h7FFF_0000), i == 0, i == ACC_MAX - 1);
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL saturation_drain pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_framing();
    bit ok;
    int err0;
    err0 = err_seen;
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b0, 1'b1);
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b1, 1'b0);
    drive_beat(fill(32'h0002_0001), fill(32'h0001_0000), 1'b0, 1'b0);
    drive_beat(fill(32'h0002_0001), fill(32'h0001_0000), 1'b1, 1'b0);
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b0, 1'b1);
    for (int i = 0; i < ACC_MAX; i++)
      drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), i == 0, 1'b0);
    drive_beat(fill(32'h0003_0000), fill(32'h0001_0000), 1'b1, 1'b1);
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL framing_drain pending=%0d required=0", exp_q.size()); end
    total++;
    if (err_seen - err0 != 3) begin
      bad++; $display("FAIL framing_err_count got=%0d required=3", err_seen - err0);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [ANT*IW-1:0] a, c;
    int n;
    for (int g = 0; g < 4; g++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < ANT; k++) begin
          a[k*IW +: IW] = $urandom;
          c[k*IW +: IW] = $urandom;
        end
        drive_beat(a, c, i == 0, i == n - 1);
      end
    end
    idle(2);
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL random_drain pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int v0;
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b1, 1'b0);
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b0, 1'b0);
    drive_beat(fill(32'h0001_0000), fill(32'h0001_0000), 1'b0, 1'b1);
    @(posedge clk); #1;
    rvalid = 1'b0; sop = 1'b0; eop = 1'b0; rst = 1'b1;
    exp_q.delete(); err_q.delete();
    m_state = 0; m_cnt = 0;
    v0 = valid_seen;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (valid_seen != v0) begin
      bad++; $display("FAIL reset_mid_valid got=%0d required=%0d", valid_seen, v0);
    end
    $display("reset_mid checked cyc=%0d", cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    fork
      run_monitor();
    join_none
    test_single();
    test_sign();
    test_accumulate();
    test_rounding();
    test_saturation();
    test_framing();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
